// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the unified RAM port arbiter.
// Owner encodings and default starvation limit.
package mem_port_arbiter_pkg;

    localparam logic [1:0] ARB_OWN_NONE = 2'd0;
    localparam logic [1:0] ARB_OWN_INST = 2'd1;
    localparam logic [1:0] ARB_OWN_DATA = 2'd2;

    localparam int ARB_STARVE_MAX = 4;
    localparam int ARB_ADDR_W     = 32;
    localparam int ARB_DATA_W     = 32;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision between IF and MEM with an anti-starvation counter.
// MEM wins conflicts unless IF has been refused STARVE_MAX times in a row.
module mem_arb_prio
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inst_req_i,
    input  logic data_req_i,
    output logic inst_gnt_o,
    output logic data_gnt_o
);

    localparam int CW = cnt_width(STARVE_MAX);
    localparam logic [CW-1:0] MAXV = CW'(STARVE_MAX);

    logic [CW-1:0] starve_q;
    logic [CW-1:0] starve_d;

    always_comb begin
        inst_gnt_o = 1'b0;
        data_gnt_o = 1'b0;
        if (!rst_i) begin
            if (inst_req_i && data_req_i) begin
                if (starve_q == MAXV) begin
                    inst_gnt_o = 1'b1;
                end else begin
                    data_gnt_o = 1'b1;
                end
            end else begin
                inst_gnt_o = inst_req_i;
                data_gnt_o = data_req_i;
            end
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (inst_gnt_o) begin
            starve_d = '0;
        end else if (inst_req_i && (starve_q != MAXV)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the unified I/D RAM port between instruction fetch and MEM.
// One access per cycle; RAM data is captured into the response registers.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int DATA_W     = ARB_DATA_W,
    parameter int STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              inst_req_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic              inst_gnt_o,
    output logic              inst_valid_o,
    output logic [DATA_W-1:0] inst_o,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    input  logic [3:0]        data_be_i,
    output logic              data_gnt_o,
    output logic              data_valid_o,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic [3:0]        ram_be_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              stallreq_o
);

    logic [1:0]        owner_q, owner_d;
    logic              dwe_q, dwe_d;
    logic              inst_valid_q, inst_valid_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic              data_valid_q, data_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inst_req_i (inst_req_i),
        .data_req_i (data_req_i),
        .inst_gnt_o (inst_gnt_o),
        .data_gnt_o (data_gnt_o)
    );

    // Grants are already zero during reset, so stall needs its own gate.
    assign stallreq_o = ~rst_i &
        ((inst_req_i & ~inst_gnt_o) | (data_req_i & ~data_gnt_o));

    always_comb begin
        ram_en_o    = inst_gnt_o | data_gnt_o;
        ram_we_o    = data_gnt_o & data_we_i;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_be_o    = 4'b0000;
        if (data_gnt_o) begin
            ram_addr_o  = data_addr_i;
            ram_wdata_o = data_wdata_i;
            ram_be_o    = data_be_i;
        end else if (inst_gnt_o) begin
            ram_addr_o  = inst_addr_i;
        end
    end

    always_comb begin
        owner_d = ARB_OWN_NONE;
        if (inst_gnt_o) begin
            owner_d = ARB_OWN_INST;
        end else if (data_gnt_o) begin
            owner_d = ARB_OWN_DATA;
        end
        dwe_d = data_gnt_o & data_we_i;
    end

    always_comb begin
        inst_valid_d = (owner_q == ARB_OWN_INST) & ~flush_i;
        inst_d       = inst_valid_d ? ram_rdata_i : inst_q;
        data_valid_d = (owner_q == ARB_OWN_DATA);
        rdata_d      = (data_valid_d && !dwe_q) ? ram_rdata_i : rdata_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q      <= ARB_OWN_NONE;
            dwe_q        <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            data_valid_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            owner_q      <= owner_d;
            dwe_q        <= dwe_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            data_valid_q <= data_valid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign inst_valid_o = inst_valid_q;
    assign inst_o       = inst_q;
    assign data_valid_o = data_valid_q;
    assign data_rdata_o = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-enabled sync RAM model.
// RAM word i holds 0xA000_0000 + i, except word 8 (0x20) = 0x1234_5678.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_gnt;
    logic        inst_valid;
    logic [31:0] inst_o;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [3:0]  data_be = '0;
    logic        data_gnt;
    logic        data_valid;
    logic [31:0] data_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic [31:0] ram_rdata = '0;
    logic        stallreq;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [256];

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .inst_req_i   (inst_req),
        .inst_addr_i  (inst_addr),
        .inst_gnt_o   (inst_gnt),
        .inst_valid_o (inst_valid),
        .inst_o       (inst_o),
        .data_req_i   (data_req),
        .data_we_i    (data_we),
        .data_addr_i  (data_addr),
        .data_wdata_i (data_wdata),
        .data_be_i    (data_be),
        .data_gnt_o   (data_gnt),
        .data_valid_o (data_valid),
        .data_rdata_o (data_rdata),
        .ram_en_o     (ram_en),
        .ram_we_o     (ram_we),
        .ram_addr_o   (ram_addr),
        .ram_wdata_o  (ram_wdata),
        .ram_be_o     (ram_be),
        .ram_rdata_i  (ram_rdata),
        .stallreq_o   (stallreq)
    );

    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we && ram_be[b])
                    mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            ram_rdata <= mem[ram_addr[9:2]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
        mem[8] = 32'h1234_5678;

        // reset with both requesters active
        inst_req  = 1'b1;
        data_req  = 1'b1;
        inst_addr = 32'h4;
        data_addr = 32'h8;
        #1;
        chk("rst_inst_gnt", 32'(inst_gnt), 32'd0);
        chk("rst_data_gnt", 32'(data_gnt), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_stall", 32'(stallreq), 32'd0);
        tick();
        tick();
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_data_valid", 32'(data_valid), 32'd0);
        chk("rst_inst_o", inst_o, 32'd0);
        chk("rst_data_rdata", data_rdata, 32'd0);
        chk("rst_starve", 32'(dut.u_prio.starve_q), 32'd0);
        rst      = 1'b0;
        inst_req = 1'b0;
        data_req = 1'b0;

        // IF only, back-to-back 0x0/0x4/0x8
        data_be = 4'hF;
        for (int k = 0; k < 5; k++) begin
            inst_req  = (k < 3);
            inst_addr = 32'(4 * k);
            #1;
            chk("if_gnt", 32'(inst_gnt), 32'(k < 3));
            chk("if_stall", 32'(stallreq), 32'd0);
            if (k < 3) begin
                chk("if_ram_addr", ram_addr, 32'(4 * k));
                chk("if_ram_be", 32'(ram_be), 32'd0);
                chk("if_ram_we", 32'(ram_we), 32'd0);
            end
            if (k >= 2) begin
                chk("if_valid", 32'(inst_valid), 32'd1);
                chk("if_word", inst_o, 32'hA000_0000 + 32'(k - 2));
            end
            tick();
        end
        chk("if_valid_end", 32'(inst_valid), 32'd0);
        chk("if_hold", inst_o, 32'hA000_0002);

        // conflict: MEM wins 4 times, then IF, then MEM again
        inst_req  = 1'b1;
        inst_addr = 32'h44;
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_addr = 32'h40;
        for (int c = 1; c <= 6; c++) begin
            #1;
            chk("cf_inst_gnt", 32'(inst_gnt), 32'(c == 5));
            chk("cf_data_gnt", 32'(data_gnt), 32'(c != 5));
            chk("cf_stall", 32'(stallreq), 32'd1);
            chk("cf_ram_addr", ram_addr, (c == 5) ? 32'h44 : 32'h40);
            chk("cf_starve", 32'(dut.u_prio.starve_q),
                (c == 6) ? 32'd0 : 32'(c - 1));
            tick();
        end
        inst_req = 1'b0;
        data_req = 1'b0;
        chk("cf_inst_valid", 32'(inst_valid), 32'd1);
        chk("cf_inst_word", inst_o, 32'hA000_0011);
        chk("cf_data_word", data_rdata, 32'hA000_0010);
        tick();
        tick();
        chk("cf_data_idle", 32'(data_valid), 32'd0);

        // store then load 0x100
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_addr  = 32'h100;
        data_wdata = 32'hDEAD_BEEF;
        data_be    = 4'hF;
        #1;
        chk("st_gnt", 32'(data_gnt), 32'd1);
        chk("st_ram_we", 32'(ram_we), 32'd1);
        chk("st_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        chk("st_ram_be", 32'(ram_be), 32'hF);
        tick();
        data_we = 1'b0;
        #1;
        chk("ld_gnt", 32'(data_gnt), 32'd1);
        chk("ld_ram_we", 32'(ram_we), 32'd0);
        tick();
        data_req = 1'b0;
        chk("st_valid", 32'(data_valid), 32'd1);
        chk("st_rdata_hold", data_rdata, 32'hA000_0010);
        tick();
        chk("ld_valid", 32'(data_valid), 32'd1);
        chk("ld_rdata", data_rdata, 32'hDEAD_BEEF);
        tick();
        chk("ld_valid_end", 32'(data_valid), 32'd0);

        // flush drops the IF response at 0x20
        inst_req  = 1'b1;
        inst_addr = 32'h20;
        #1;
        chk("fl_gnt", 32'(inst_gnt), 32'd1);
        tick();
        inst_req = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid", 32'(inst_valid), 32'd0);
        chk("fl_hold", inst_o, 32'hA000_0011);
        tick();
        chk("fl_valid2", 32'(inst_valid), 32'd0);
        inst_req = 1'b1;
        tick();
        inst_req = 1'b0;
        tick();
        chk("nf_valid", 32'(inst_valid), 32'd1);
        chk("nf_word", inst_o, 32'h1234_5678);

        // reset while a DATA read is in flight
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_addr = 32'h100;
        #1;
        chk("rm_gnt", 32'(data_gnt), 32'd1);
        tick();
        data_req = 1'b0;
        inst_req = 1'b1;
        rst      = 1'b1;
        #1;
        chk("rm_inst_gnt", 32'(inst_gnt), 32'd0);
        chk("rm_ram_en", 32'(ram_en), 32'd0);
        chk("rm_stall", 32'(stallreq), 32'd0);
        tick();
        rst      = 1'b0;
        inst_req = 1'b0;
        chk("rm_data_valid", 32'(data_valid), 32'd0);
        chk("rm_data_rdata", data_rdata, 32'd0);
        chk("rm_inst_o", inst_o, 32'd0);
        chk("rm_owner", 32'(dut.owner_q), 32'd0);
        tick();
        chk("rm_data_valid2", 32'(data_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data port of the unified instruction/data RAM between two requesters: instruction fetch (IF, driven by the PC) and the load/store stage (MEM).
- Sits between pc_reg/mem and the RAM.
- Grants one access per cycle and returns the response one cycle later.
- Raises a stall request to pipe_ctrl whenever a requester is refused.

Parameters:
ADDR_W, 32, byte-address width (matches `ADDR_WIDTH)
DATA_W, 32, data width (matches `DATA_WIDTH)
STARVE_MAX, 4, consecutive IF refusals before IF wins the next conflict

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
flush_i  in  1  pipeline flush (jump); discards in-flight IF response
inst_req_i  in  1  IF read request
inst_addr_i  in  ADDR_W  IF byte address
inst_gnt_o  out  1  IF request accepted this cycle (combinational)
inst_valid_o  out  1  IF response valid (registered)
inst_o  out  DATA_W  fetched word; holds last valid value
data_req_i  in  1  MEM request
data_we_i  in  1  1 = write, 0 = read
data_addr_i  in  ADDR_W  MEM byte address
data_wdata_i  in  DATA_W  write data
data_be_i  in  4  byte enables for writes
data_gnt_o  out  1  MEM request accepted this cycle (combinational)
data_valid_o  out  1  MEM response valid (reads and writes)
data_rdata_o  out  DATA_W  load data; holds last valid value
ram_en_o  out  1  RAM access strobe
ram_we_o  out  1  RAM write enable
ram_addr_o  out  ADDR_W  RAM byte address
ram_wdata_o  out  DATA_W  RAM write data
ram_be_o  out  4  RAM byte enables
ram_rdata_i  in  DATA_W  RAM read data, valid the cycle after ram_en_o
stallreq_o  out  1  to pipe_ctrl: a requester was refused this cycle

Behaviour:
- Reset (rst_i = 1 at a clock edge):
  - owner = NONE, starve_cnt = 0.
  - inst_valid_o = 0, data_valid_o = 0, inst_o = 0, data_rdata_o = 0.
  - Any in-flight response is dropped.
  - While rst_i is high, both grants are 0, ram_en_o = 0 and stallreq_o = 0.
- Arbitration (combinational, cycle N):
  - Only one requester: it is granted.
  - Both requesting: MEM wins, unless starve_cnt == STARVE_MAX, in which case IF wins.
- RAM drive in cycle N:
  - ram_en_o = inst_gnt_o | data_gnt_o.
  - The granted port's address, data and byte enables are driven to the RAM.
  - ram_we_o = data_gnt_o & data_we_i.
  - IF access drives ram_be_o = 4'b0000 and ram_wdata_o = 0.
- Owner register records who holds the in-flight access: NONE / INST / DATA. Updated every cycle from the grants.
- Response (cycle N+1):
  - owner == INST: inst_valid_o = 1, inst_o <= ram_rdata_i.
  - owner == DATA: data_valid_o = 1; for reads, data_rdata_o <= ram_rdata_i; for writes, data_rdata_o is unchanged.
  - Valid pulses last exactly one cycle per grant.
- Handshake:
  - A requester holds req and its operands stable until gnt is seen.
  - It may present a new request in the cycle after gnt.
  - Continuous req with gnt every cycle gives back-to-back accesses, one per cycle.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) each cycle IF requests and is refused.
  - Cleared to 0 on inst_gnt_o.
  - Unchanged when IF is not requesting.
- stallreq_o = (inst_req_i & ~inst_gnt_o) | (data_req_i & ~data_gnt_o).
- Flush:
  - flush_i in cycle N+1 while owner == INST forces inst_valid_o = 0 and leaves inst_o unchanged.
  - flush_i does not affect DATA responses or the current cycle's arbitration.
- Simultaneous events:
  - Reset overrides flush and all requests.
  - A write and a read to the same address in consecutive cycles see the written value.

Decomposition:
- Add to defines.v: ARB_OWN_NONE = 2'd0, ARB_OWN_INST = 2'd1, ARB_OWN_DATA = 2'd2, and ARB_STARVE_MAX default.
- One sub-module, mem_arb_prio: holds starve_cnt and the grant decision; inputs are the two reqs, outputs are the two gnts.
- The top of mem_port_arbiter contains the RAM mux, the owner register and the response/hold registers.

Test Plan:
- Reset then idle: rst_i high 2 cycles with both reqs high -> gnts 0, ram_en_o 0, all outputs 0, starve_cnt 0.
- IF only: inst_req_i = 1, addrs 0x0, 0x4, 0x8 back-to-back:
  - inst_gnt_o high 3 cycles, ram_addr_o 0x0/0x4/0x8.
  - inst_valid_o high the next 3 cycles with the matching RAM words; stallreq_o = 0.
- Conflict and starvation (STARVE_MAX = 4): both reqs held high:
  - data_gnt_o for 4 cycles, inst_gnt_o on cycle 5, then data again.
  - stallreq_o = 1 on every cycle where IF is refused.
- Store/load: write 0xDEADBEEF to 0x100 with be = 4'b1111, then read 0x100:
  - data_valid_o pulses twice; data_rdata_o = 0xDEADBEEF after the second.
- Flush: IF granted at 0x20 (RAM word 0x12345678), flush_i = 1 the next cycle -> inst_valid_o = 0, inst_o keeps its prior value.
- Reset mid-operation: DATA read granted, rst_i = 1 the next cycle -> data_valid_o = 0, data_rdata_o = 0, owner NONE.
